// File: rtl/dmem_arbiter_if.sv
// Shared data-memory bus: two requester ports plus the memory-side strobes.
// The slave modport is the arbiter; the master modport is the surrounding environment.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_we, mem_re, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_we, mem_re, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-ported data memory: one access per cycle,
// alternating priority on ties, registered read data with a one-cycle rvalid pulse.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SERVE0 = 2'd1;
    localparam logic [1:0] SERVE1 = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              acc_we_q,     acc_we_d;
    logic [ADDR_W-1:0] acc_addr_q,   acc_addr_d;
    logic [DATA_W-1:0] acc_wdata_q,  acc_wdata_d;
    logic              p0_rvalid_q,  p0_rvalid_d;
    logic              p1_rvalid_q,  p1_rvalid_d;
    logic [DATA_W-1:0] p0_rdata_q,   p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q,   p1_rdata_d;

    logic elig0;
    logic elig1;
    logic serving;

    always_comb begin
        elig0   = bus.p0_req && (state_q != SERVE0);
        elig1   = bus.p1_req && (state_q != SERVE1);
        serving = (state_q == SERVE0) || (state_q == SERVE1);

        state_d      = IDLE;
        last_grant_d = last_grant_q;
        acc_we_d     = acc_we_q;
        acc_addr_d   = acc_addr_q;
        acc_wdata_d  = acc_wdata_q;

        // On a tie the port that was not granted most recently wins.
        if (elig0 && elig1) begin
            state_d = last_grant_q ? SERVE0 : SERVE1;
        end else if (elig0) begin
            state_d = SERVE0;
        end else if (elig1) begin
            state_d = SERVE1;
        end

        if (state_d == SERVE0) begin
            last_grant_d = 1'b0;
            acc_we_d     = bus.p0_we;
            acc_addr_d   = bus.p0_addr;
            acc_wdata_d  = bus.p0_wdata;
        end else if (state_d == SERVE1) begin
            last_grant_d = 1'b1;
            acc_we_d     = bus.p1_we;
            acc_addr_d   = bus.p1_addr;
            acc_wdata_d  = bus.p1_wdata;
        end

        p0_rvalid_d = (state_q == SERVE0) && !acc_we_q;
        p1_rvalid_d = (state_q == SERVE1) && !acc_we_q;
        p0_rdata_d  = p0_rvalid_d ? bus.mem_rdata : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? bus.mem_rdata : p1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            acc_we_q     <= 1'b0;
            acc_addr_q   <= '0;
            acc_wdata_q  <= '0;
            p0_rvalid_q  <= 1'b0;
            p1_rvalid_q  <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            acc_we_q     <= acc_we_d;
            acc_addr_q   <= acc_addr_d;
            acc_wdata_q  <= acc_wdata_d;
            p0_rvalid_q  <= p0_rvalid_d;
            p1_rvalid_q  <= p1_rvalid_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    // Strobes are masked while rst_n is low so an access caught by reset never commits.
    assign bus.mem_we    = serving &&  acc_we_q && rst_n;
    assign bus.mem_re    = serving && !acc_we_q && rst_n;
    assign bus.mem_addr  = acc_addr_q;
    assign bus.mem_wdata = acc_wdata_q;

    assign bus.p0_gnt    = (state_q == SERVE0);
    assign bus.p1_gnt    = (state_q == SERVE1);
    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5: word-address width of the shared data memory.
REQ-002 Parameter DATA_W, default 32: data width of the shared data memory.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 p0_req / p1_req  input  1  access request from port 0 (pipeline MEM stage) / port 1 (debug/DMA).
REQ-006 p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-007 p0_addr / p1_addr  input  ADDR_W  access address.
REQ-008 p0_wdata / p1_wdata  input  DATA_W  write data.
REQ-009 p0_gnt / p1_gnt  output  1  access accepted this cycle.
REQ-010 p0_rvalid / p1_rvalid  output  1  one-cycle pulse: read data valid.
REQ-011 p0_rdata / p1_rdata  output  DATA_W  registered read data.
REQ-012 mem_we / mem_re  output  1  memory write strobe / read strobe.
REQ-013 mem_addr  output  ADDR_W  memory address.
REQ-014 mem_wdata  output  DATA_W  memory write data.
REQ-015 mem_rdata  input  DATA_W  memory read data, combinational from mem_addr.

Function
REQ-016 FSM states: IDLE, SERVE0, SERVE1; exactly one state per cycle.
REQ-017 Eligible requesters each cycle: px_req high AND state != SERVEx (port currently granted is not re-arbitrated that cycle).
REQ-018 Next state: SERVEx if only port x eligible; if both eligible, port != last_grant wins; IDLE if none eligible.
REQ-019 last_grant register updates to x on every entry into SERVEx; resets to 1 (port 0 wins first tie).
REQ-020 On the edge entering SERVEx, latch px_we, px_addr, px_wdata into access registers.
REQ-021 px_gnt = (state == SERVEx); requester holds req/we/addr/wdata stable until it samples gnt high, then may change or drop them.
REQ-022 In SERVEx: mem_addr/mem_wdata = latched values; mem_we = latched we; mem_re = NOT latched we; in IDLE mem_we = mem_re = 0, mem_addr/mem_wdata hold last values.
REQ-023 Latency: req sampled at edge N -> gnt and memory strobe during cycle N+1 -> write committed at edge N+1 -> rvalid and rdata in cycle N+2.
REQ-024 Read in SERVEx: mem_rdata captured into px_rdata at end of SERVEx; px_rvalid high exactly the following cycle.
REQ-025 px_rdata holds its value until the next read for port x; writes never pulse rvalid.
REQ-026 Throughput: back-to-back SERVE states allowed; with both ports continuously requesting, grants alternate 0,1,0,1 (one access per cycle).
REQ-027 Write at cycle N then read of same address at cycle N+1 returns new data.
REQ-028 At most one of mem_we, mem_re, p0_gnt, p1_gnt-pair active per cycle; p0_gnt and p1_gnt never both high.

Reset
REQ-029 rst_n low at a posedge: state IDLE, last_grant = 1, all gnt/rvalid/mem_we/mem_re = 0, mem_addr/mem_wdata/p0_rdata/p1_rdata/access registers = 0.
REQ-030 Reset during SERVEx: access in flight aborted; no memory strobe and no rvalid in the cycle after reset.
REQ-031 Requests are ignored while rst_n low; arbitration resumes on the first edge with rst_n high.

Verification
REQ-032 p0 write addr 3 data 0xDEADBEEF, idle p1 -> p0_gnt 1 cycle later, mem_we=1 mem_addr=3 mem_wdata=0xDEADBEEF for one cycle, no rvalid.
REQ-033 p1 read addr 3 after REQ-032 -> p1_gnt, mem_re=1, next cycle p1_rvalid=1 p1_rdata=0xDEADBEEF.
REQ-034 Both ports request continuously from reset -> grant sequence 0,1,0,1 with no IDLE gaps.
REQ-035 p0 write addr 7 = 0x12345678 granted cycle N, p1 read addr 7 granted N+1 -> p1_rdata = 0x12345678.
REQ-036 rst_n low during SERVE0 write -> mem_we 0 next cycle, gnt/rvalid 0, memory contents unchanged.
REQ-037 Single request on p0 only, p0_req dropped after gnt -> exactly one access, FSM returns to IDLE.
